dvp_stream_rx: RTL and testbench

- Parametrised DVP (camera parallel port) receiver that packs BYTES_PER_PIXEL input beats into one pixel.
- Emits pixels as AXI4-Stream video: tuser marks start of frame, tlast marks end of line, tready applies backpressure.
- A small output FIFO absorbs downstream stalls; overflow drops the rest of the frame and raises a sticky flag.
- Sits directly behind the camera pins in the pclk domain, ahead of the CDC/DMA stage.

---
 rtl/dvp_stream_rx.sv | 204 ++++++++++++++++++++
 tb/tb_dvp_stream_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_stream_rx.sv
// DVP camera receiver: packs BYTES_PER_PIXEL beats per pixel and emits an AXI4-Stream
// video stream (tuser = start of frame, tlast = end of line) through a small output FIFO.
module dvp_stream_rx #(
  parameter int DIN_W           = 8,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int FIFO_DEPTH      = 16,
  parameter int CNT_W           = 12
) (
  input  logic                             pclk,
  input  logic                             rst,
  input  logic [DIN_W-1:0]                 din,
  input  logic                             href,
  input  logic                             vsync,
  output logic [DIN_W*BYTES_PER_PIXEL-1:0] m_axis_tdata,
  output logic                             m_axis_tuser,
  output logic                             m_axis_tlast,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [CNT_W-1:0]                 line_width,
  output logic [CNT_W-1:0]                 frame_height,
  output logic                             overflow,
  output logic                             line_err,
  input  logic                             err_clr
);

  localparam int PIX_W = DIN_W * BYTES_PER_PIXEL;
  localparam int ENT_W = PIX_W + 2;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_PIXEL - 1);
  localparam logic [AW:0] FULL_OCC  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    BLANK  = 2'd1,
    ACTIVE = 2'd2,
    DROP   = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) r = v;
    else    r = v + CNT_W'(1);
    return r;
  endfunction

  state_t           state_q;
  logic             href_q, vsync_q;
  logic [1:0]       byte_cnt_q;
  logic [PIX_W-1:0] asm_q, stage_q;
  logic             stage_valid_q, sof_pending_q;
  logic [CNT_W-1:0] pix_cnt_q, line_cnt_q, line_width_q, frame_height_q;
  logic             overflow_q, line_err_q;

  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      mem_cnt_q, mem_cnt_d;
  logic [ENT_W-1:0] out_q;
  logic             out_valid_q;

  logic             vsync_rise_s, href_fall_s, beat_s, pix_done_s, line_end_s;
  logic             push_req_s, push_s, ovf_s, pop_s, load_s, full_s;
  logic [PIX_W-1:0] asm_next_s;
  logic [ENT_W-1:0] push_ent_s;

  // Event decode; occupancy counts the output register so capacity is exactly FIFO_DEPTH
  always_comb begin
    vsync_rise_s = vsync & ~vsync_q;
    href_fall_s  = href_q & ~href;
    beat_s       = (state_q == ACTIVE) & href & ~vsync_rise_s;
    pix_done_s   = beat_s & (byte_cnt_q == LAST_BYTE);
    line_end_s   = (state_q == ACTIVE) & href_fall_s & ~vsync_rise_s;
    asm_next_s   = (asm_q << DIN_W) | PIX_W'(din);
    push_req_s   = stage_valid_q & (pix_done_s | line_end_s);
    push_ent_s   = {sof_pending_q, line_end_s, stage_q};
    pop_s        = out_valid_q & m_axis_tready;
    full_s       = (mem_cnt_q + {{AW{1'b0}}, out_valid_q}) == FULL_OCC;
    ovf_s        = push_req_s & full_s & ~pop_s;
    push_s       = push_req_s & ~ovf_s;
    load_s       = (mem_cnt_q != '0) & (~out_valid_q | pop_s);
    mem_cnt_d    = mem_cnt_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, load_s};
  end

  // Frame/line sequencing, beat packing and the one-pixel stage that decides tlast
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q        <= SYNC;
      href_q         <= 1'b0;
      vsync_q        <= 1'b1;
      byte_cnt_q     <= 2'd0;
      asm_q          <= '0;
      stage_q        <= '0;
      stage_valid_q  <= 1'b0;
      sof_pending_q  <= 1'b0;
      pix_cnt_q      <= '0;
      line_cnt_q     <= '0;
      line_width_q   <= '0;
      frame_height_q <= '0;
    end else begin
      href_q  <= href;
      vsync_q <= vsync;
      case (state_q)
        SYNC: begin
          if (vsync_rise_s) state_q <= BLANK;
        end
        BLANK: begin
          if (!vsync) begin
            state_q       <= ACTIVE;
            sof_pending_q <= 1'b1;
            line_cnt_q    <= '0;
            pix_cnt_q     <= '0;
            byte_cnt_q    <= 2'd0;
            stage_valid_q <= 1'b0;
          end
        end
        ACTIVE: begin
          if (vsync_rise_s) begin
            state_q        <= BLANK;
            frame_height_q <= line_cnt_q;
            stage_valid_q  <= 1'b0;
            byte_cnt_q     <= 2'd0;
          end else if (ovf_s) begin
            state_q       <= DROP;
            stage_valid_q <= 1'b0;
            byte_cnt_q    <= 2'd0;
          end else begin
            if (push_s) sof_pending_q <= 1'b0;
            if (pix_done_s) begin
              byte_cnt_q    <= 2'd0;
              asm_q         <= asm_next_s;
              stage_q       <= asm_next_s;
              stage_valid_q <= 1'b1;
              pix_cnt_q     <= sat_inc(pix_cnt_q);
            end else if (beat_s) begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
              asm_q      <= asm_next_s;
            end else if (line_end_s) begin
              // Partial trailing bytes are simply forgotten; the line still closes
              byte_cnt_q    <= 2'd0;
              pix_cnt_q     <= '0;
              stage_valid_q <= 1'b0;
              if (stage_valid_q) begin
                line_width_q <= pix_cnt_q;
                line_cnt_q   <= sat_inc(line_cnt_q);
              end
            end
          end
        end
        DROP: begin
          if (vsync_rise_s) state_q <= BLANK;
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  // Sticky error flags; a new event wins over a simultaneous clear
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      line_err_q <= 1'b0;
    end else begin
      if (ovf_s)        overflow_q <= 1'b1;
      else if (err_clr) overflow_q <= 1'b0;
      if (line_end_s && (byte_cnt_q != 2'd0)) line_err_q <= 1'b1;
      else if (err_clr)                       line_err_q <= 1'b0;
    end
  end

  // FIFO pointers and registered output stage
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      mem_cnt_q <= mem_cnt_d;
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (load_s) begin
        out_q       <= mem_q[rd_ptr_q];
        out_valid_q <= 1'b1;
        rd_ptr_q    <= rd_ptr_q + AW'(1);
      end else if (pop_s) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // FIFO storage
  always_ff @(posedge pclk) begin
    if (push_s) mem_q[wr_ptr_q] <= push_ent_s;
  end

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tuser  = out_q[ENT_W-1];
  assign m_axis_tlast  = out_q[ENT_W-2];
  assign m_axis_tdata  = out_q[PIX_W-1:0];
  assign line_width    = line_width_q;
  assign frame_height  = frame_height_q;
  assign overflow      = overflow_q;
  assign line_err      = line_err_q;

endmodule

// File: tb/tb_dvp_stream_rx.sv
// Scoreboard bench for dvp_stream_rx: expected {tuser,tlast,data} entries are queued as
// beats are driven and compared in order against every accepted AXI-Stream transfer.
module tb_dvp_stream_rx;

  localparam int DIN_W = 8;
  localparam int BPP   = 2;
  localparam int DEPTH = 16;
  localparam int CNT_W = 12;

  logic             pclk = 1'b0;
  logic             rst, href, vsync, err_clr, tready;
  logic [7:0]       din;
  logic [15:0]      tdata;
  logic             tuser, tlast, tvalid, overflow, line_err;
  logic [CNT_W-1:0] line_width, frame_height;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_xfer   = 0;
  int          base;
  logic [17:0] exp_q[$];
  logic        sof_exp  = 1'b0;
  logic [7:0]  bval     = 8'h00;
  logic        rand_rdy = 1'b0;
  logic        rdy_fixed = 1'b1;

  always #5 pclk = ~pclk;

  dvp_stream_rx #(
    .DIN_W(DIN_W), .BYTES_PER_PIXEL(BPP), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .pclk(pclk), .rst(rst), .din(din), .href(href), .vsync(vsync),
    .m_axis_tdata(tdata), .m_axis_tuser(tuser), .m_axis_tlast(tlast),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .line_width(line_width), .frame_height(frame_height),
    .overflow(overflow), .line_err(line_err), .err_clr(err_clr)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic [7:0] d, input logic h, input logic v);
    din = d; href = h; vsync = v;
    @(posedge pclk); #1;
  endtask

  task automatic start_frame(input logic expect_out);
    repeat (2) cyc(8'h00, 1'b0, 1'b1);
    repeat (4) cyc(8'h00, 1'b0, 1'b0);
    sof_exp = expect_out;
  endtask

  // Drives nbytes beats; only the first 'keep' pixels are expected at the output
  task automatic send_line(input int nbytes, input int keep);
    logic [7:0] hi;
    int npix;
    hi   = 8'h00;
    npix = nbytes / 2;
    for (int i = 0; i < nbytes; i++) begin
      if (i % 2 == 0) begin
        hi = bval;
      end else if (i / 2 < keep) begin
        exp_q.push_back({sof_exp, (i / 2 == npix - 1), hi, bval});
        sof_exp = 1'b0;
      end
      cyc(bval, 1'b1, 1'b0);
      bval = bval + 8'd1;
    end
    repeat (6) cyc(8'h00, 1'b0, 1'b0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    cyc(8'h00, 1'b0, 1'b0);
    err_clr = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !tvalid) break;
      @(posedge pclk); #1;
    end
    check_value("drain_remaining", 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge pclk) begin
    if (!rst && tvalid && tready) begin
      n_xfer++;
      if (exp_q.size() == 0) check_value("spurious_xfer_expq_size", 32'(exp_q.size()), 32'd1);
      else                   check_value("xfer", 32'({tuser, tlast, tdata}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge pclk); #2;
      if (rand_rdy) tready = 1'($urandom_range(0, 1));
      else          tready = rdy_fixed;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; din = 8'h00; href = 1'b0; vsync = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge pclk); #1;
    check_value("rst_tvalid", 32'(tvalid), 32'd0);
    check_value("rst_tdata", 32'(tdata), 32'd0);
    check_value("rst_tuser", 32'(tuser), 32'd0);
    check_value("rst_tlast", 32'(tlast), 32'd0);
    check_value("rst_line_width", 32'(line_width), 32'd0);
    check_value("rst_frame_height", 32'(frame_height), 32'd0);
    check_value("rst_overflow", 32'(overflow), 32'd0);
    check_value("rst_line_err", 32'(line_err), 32'd0);
    rst = 1'b0;

    // Mid-frame start: lines before any vsync must be ignored
    bval = 8'hA0;
    send_line(8, 0);
    send_line(8, 0);
    check_value("midframe_xfers", 32'(n_xfer), 32'd0);

    // 3 lines x 4 pixels, bytes 0x01..0x18
    base = n_xfer;
    start_frame(1'b1);
    bval = 8'h01;
    repeat (3) send_line(8, 4);
    wait_drain();
    check_value("frame1_xfers", 32'(n_xfer - base), 32'd12);
    start_frame(1'b1);
    check_value("frame1_height", 32'(frame_height), 32'd3);
    check_value("frame1_width", 32'(line_width), 32'd4);

    // 7-byte line: 3 pixels, partial byte flagged
    base = n_xfer;
    send_line(7, 3);
    check_value("partial_line_err", 32'(line_err), 32'd1);
    check_value("partial_width", 32'(line_width), 32'd3);
    pulse_clr();
    check_value("line_err_cleared", 32'(line_err), 32'd0);
    wait_drain();
    check_value("partial_xfers", 32'(n_xfer - base), 32'd3);

    // Overflow: stalled sink, 24-pixel line, only the first DEPTH pixels survive
    start_frame(1'b1);
    check_value("partial_frame_height", 32'(frame_height), 32'd1);
    rdy_fixed = 1'b0;
    base = n_xfer;
    send_line(48, DEPTH);
    check_value("ovf_set", 32'(overflow), 32'd1);
    check_value("ovf_no_xfer_while_stalled", 32'(n_xfer - base), 32'd0);
    rdy_fixed = 1'b1;
    wait_drain();
    check_value("ovf_drained", 32'(n_xfer - base), 32'(DEPTH));
    base = n_xfer;
    start_frame(1'b1);
    repeat (2) send_line(8, 4);
    wait_drain();
    check_value("after_ovf_xfers", 32'(n_xfer - base), 32'd8);
    check_value("ovf_sticky", 32'(overflow), 32'd1);
    pulse_clr();
    check_value("ovf_cleared", 32'(overflow), 32'd0);

    // Random backpressure over two 16x8 frames
    base = n_xfer;
    rand_rdy = 1'b1;
    start_frame(1'b1);
    repeat (8) send_line(32, 16);
    start_frame(1'b1);
    repeat (8) send_line(32, 16);
    start_frame(1'b0);
    rand_rdy = 1'b0;
    rdy_fixed = 1'b1;
    wait_drain();
    check_value("rand_xfers", 32'(n_xfer - base), 32'd256);
    check_value("rand_no_ovf", 32'(overflow), 32'd0);
    check_value("rand_height", 32'(frame_height), 32'd8);
    check_value("rand_width", 32'(line_width), 32'd16);

    // Reset in the middle of a line with one pixel waiting at the output
    start_frame(1'b1);
    rdy_fixed = 1'b0;
    repeat (5) begin
      cyc(bval, 1'b1, 1'b0);
      bval = bval + 8'd1;
    end
    check_value("pre_rst_tvalid", 32'(tvalid), 32'd1);
    rst = 1'b1;
    #1;
    check_value("midrst_tvalid", 32'(tvalid), 32'd0);
    check_value("midrst_tdata", 32'(tdata), 32'd0);
    check_value("midrst_width", 32'(line_width), 32'd0);
    check_value("midrst_overflow", 32'(overflow), 32'd0);
    exp_q.delete();
    @(posedge pclk); #1;
    rst = 1'b0;
    rdy_fixed = 1'b1;
    base = n_xfer;
    repeat (5) begin
      cyc(bval, 1'b1, 1'b0);
      bval = bval + 8'd1;
    end
    repeat (6) cyc(8'h00, 1'b0, 1'b0);
    check_value("post_rst_ignored", 32'(n_xfer - base), 32'd0);
    start_frame(1'b1);
    repeat (2) send_line(8, 4);
    start_frame(1'b0);
    wait_drain();
    check_value("post_rst_xfers", 32'(n_xfer - base), 32'd8);
    check_value("post_rst_height", 32'(frame_height), 32'd2);

    repeat (20) @(posedge pclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
